// File: rtl/shift_pkg.sv
// shift_pkg: shared constants for the shift sequencer
// mode codes and FSM state encodings
package shift_pkg;

   localparam logic [1:0] SEL_LSL = 2'b00;
   localparam logic [1:0] SEL_LSR = 2'b01;
   localparam logic [1:0] SEL_ASL = 2'b10;
   localparam logic [1:0] SEL_ASR = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/shift_step.sv
// shift_step: one-bit shift of the operand
// purely combinational, one mode per sel code
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] out
);

   // left shifts fill zero; right shifts fill zero or sign
   always_comb begin
      out = in;
      unique case (sel)
         SEL_LSL,
         SEL_ASL: out = {in[WIDTH-2:0], 1'b0};
         SEL_LSR: out = {1'b0, in[WIDTH-1:1]};
         SEL_ASR: out = {in[WIDTH-1], in[WIDTH-1:1]};
         default: out = in;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift controller
// one single-bit step per clock until amount reached
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       sel,
   input  logic [AMT_W-1:0] amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             busy
);

   logic [1:0]       state;
   logic [WIDTH-1:0] data;
   logic [1:0]       mode;
   logic [AMT_W:0]   cnt;
   logic [AMT_W:0]   eff;
   logic [WIDTH-1:0] step;

   shift_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .in  (data),
      .sel (mode),
      .out (step)
   );

   // clamp the requested amount to WIDTH shifts
   always_comb begin
      eff = {1'b0, amt};
      if (32'(amt) >= 32'(WIDTH))
         eff = (AMT_W+1)'(WIDTH);
   end

   // FSM, operand register and step counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         data  <= '0;
         mode  <= '0;
         cnt   <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  data  <= in;
                  mode  <= sel;
                  cnt   <= eff;
                  state <= (eff == '0) ? ST_DONE : ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               data <= step;
               cnt  <= cnt - 1'b1;
               if (cnt == (AMT_W+1)'(1))
                  state <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // handshake flags decode from state only
   always_comb begin
      in_ready  = (state == ST_IDLE);
      out_valid = (state == ST_DONE);
      busy      = (state != ST_IDLE);
      out       = data;
   end

endmodule
